// File: rtl/data_island_multi_packet_serializer_if.sv
// data_island_multi_packet_serializer_if: packet push (valid/ready/header/subpackets), sync and island request in; fifo status, island flags and TERC4 nibbles out
interface data_island_multi_packet_serializer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_PACKETS = 18
);
  logic packet_valid;
  logic packet_ready;
  logic [23:0] header;
  logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;
  logic hsync, vsync;
  logic island_start;
  logic [$clog2(MAX_PACKETS+1)-1:0] pending_packets;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level;
  logic island_active, packet_first_clock, island_last_clock;
  logic [3:0] terc4_channel0, terc4_channel1, terc4_channel2;
  modport master (
    output packet_valid, header, subpacket0, subpacket1, subpacket2, subpacket3, hsync, vsync, island_start,
    input packet_ready, pending_packets, fifo_level, island_active, packet_first_clock, island_last_clock,
    input terc4_channel0, terc4_channel1, terc4_channel2
  );
  modport slave (
    input packet_valid, header, subpacket0, subpacket1, subpacket2, subpacket3, hsync, vsync, island_start,
    output packet_ready, pending_packets, fifo_level, island_active, packet_first_clock, island_last_clock,
    output terc4_channel0, terc4_channel1, terc4_channel2
  );
endinterface

// File: rtl/data_island_multi_packet_serializer.sv
// data_island_multi_packet_serializer: FIFO-buffered HDMI data island packets sent as 1..MAX_PACKETS back-to-back 32-clock packets with on-the-fly BCH ECC; ports clk, rst, bus (slave modport)
module data_island_multi_packet_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_PACKETS = 18
) (
  input logic clk,
  input logic rst,
  data_island_multi_packet_serializer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(MAX_PACKETS+1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [23:0] hdr_mem [FIFO_DEPTH];
  logic [55:0] sp_mem [FIFO_DEPTH][4];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [4:0] k, nk;
  logic [PW-1:0] p, n;
  logic [23:0] hsh;
  logic [55:0] ssh [4];
  logic [7:0] hecc, hecc_nx;
  logic [7:0] secc [4];
  logic [7:0] secc_nx [4];
  logic [1:0] sb [4];
  logic [3:0] c1_nx, c2_nx;
  logic [2:0] hi;
  logic [1:0] si;
  logic push, last_clk, go, start_pkt, active_nx, hb;
  function automatic logic [7:0] ecc1(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction
  assign bus.packet_ready = level < LW'(FIFO_DEPTH);
  assign bus.fifo_level = level;
  assign bus.pending_packets = (32'(level) > MAX_PACKETS) ? PW'(MAX_PACKETS) : PW'(level);
  assign push = bus.packet_valid && bus.packet_ready;
  // Everything below describes the packet clock nk that appears on the outputs after the next edge.
  always_comb begin
    last_clk = state == SEND && k == 5'd31 && p == n - 1'b1;
    go = bus.island_start && bus.pending_packets != '0 && (state == IDLE || last_clk);
    start_pkt = go || (state == SEND && k == 5'd31 && !last_clk);
    active_nx = start_pkt || (state == SEND && k != 5'd31);
    nk = start_pkt ? 5'd0 : k + 5'd1;
    hi = 3'(nk - 5'd24);
    si = 2'(nk - 5'd28);
    hb = start_pkt ? hdr_mem[rd_ptr][0] : hsh[0];
    hecc_nx = nk < 5'd24 ? ecc1(start_pkt ? 8'h00 : hecc, hb) : hecc;
    for (int s = 0; s < 4; s++) begin
      sb[s] = start_pkt ? sp_mem[rd_ptr][s][1:0] : ssh[s][1:0];
      secc_nx[s] = nk < 5'd28 ? ecc1(ecc1(start_pkt ? 8'h00 : secc[s], sb[s][0]), sb[s][1]) : secc[s];
      c1_nx[s] = nk < 5'd28 ? sb[s][0] : secc[s][{si, 1'b0}];
      c2_nx[s] = nk < 5'd28 ? sb[s][1] : secc[s][{si, 1'b1}];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        hdr_mem[wr_ptr] <= bus.header;
        sp_mem[wr_ptr][0] <= bus.subpacket0;
        sp_mem[wr_ptr][1] <= bus.subpacket1;
        sp_mem[wr_ptr][2] <= bus.subpacket2;
        sp_mem[wr_ptr][3] <= bus.subpacket3;
        wr_ptr <= wr_ptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(start_pkt);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      p <= '0;
      n <= '0;
      rd_ptr <= '0;
      hsh <= '0;
      hecc <= '0;
      for (int s = 0; s < 4; s++) begin
        ssh[s] <= '0;
        secc[s] <= '0;
      end
      bus.island_active <= 1'b0;
      bus.packet_first_clock <= 1'b0;
      bus.island_last_clock <= 1'b0;
      bus.terc4_channel0 <= '0;
      bus.terc4_channel1 <= '0;
      bus.terc4_channel2 <= '0;
    end else begin
      if (go) begin
        state <= SEND;
        n <= bus.pending_packets;
        p <= '0;
      end else if (state == SEND && k == 5'd31) begin
        if (last_clk) state <= IDLE;
        else p <= p + 1'b1;
      end
      k <= active_nx ? nk : 5'd0;
      if (start_pkt) rd_ptr <= rd_ptr + 1'b1;
      hsh <= start_pkt ? hdr_mem[rd_ptr] >> 1 : hsh >> 1;
      hecc <= hecc_nx;
      for (int s = 0; s < 4; s++) begin
        ssh[s] <= start_pkt ? sp_mem[rd_ptr][s] >> 2 : ssh[s] >> 2;
        secc[s] <= secc_nx[s];
      end
      bus.island_active <= active_nx;
      bus.packet_first_clock <= start_pkt;
      bus.island_last_clock <= state == SEND && k == 5'd30 && p == n - 1'b1;
      bus.terc4_channel0 <= {active_nx && nk != 5'd0, active_nx && (nk < 5'd24 ? hb : hecc[hi]), bus.vsync, bus.hsync};
      bus.terc4_channel1 <= active_nx ? c1_nx : 4'd0;
      bus.terc4_channel2 <= active_nx ? c2_nx : 4'd0;
    end
  end
endmodule

// File: tb/tb_data_island_multi_packet_serializer.sv
// tb_data_island_multi_packet_serializer: scoreboard bench comparing the TERC4 stream against a software BCH packet model
module tb_data_island_multi_packet_serializer;
  localparam int FD = 4;
  localparam int MP = 2;
  typedef struct packed {logic [23:0] h; logic [55:0] s0, s1, s2, s3;} pkt_t;
  typedef struct packed {logic act, first, last; logic [3:0] c0, c1, c2;} obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  pkt_t pkt_q[$];
  obs_t exp_q[$];
  data_island_multi_packet_serializer_if #(.FIFO_DEPTH(FD), .MAX_PACKETS(MP)) bus();
  data_island_multi_packet_serializer #(.FIFO_DEPTH(FD), .MAX_PACKETS(MP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bch(input logic [55:0] d, input int nb);
    logic [7:0] r = '0;
    for (int i = 0; i < nb; i++) r = {1'b0, r[7:1]} ^ ((r[0] ^ d[i]) ? 8'b1000_0011 : 8'h00);
    return r;
  endfunction
  function automatic pkt_t rand_pkt();
    pkt_t pk;
    pk.h = 24'($urandom);
    pk.s0 = 56'({$urandom, $urandom});
    pk.s1 = 56'({$urandom, $urandom});
    pk.s2 = 56'({$urandom, $urandom});
    pk.s3 = 56'({$urandom, $urandom});
    return pk;
  endfunction
  function automatic obs_t sample();
    return {bus.island_active, bus.packet_first_clock, bus.island_last_clock,
            bus.terc4_channel0, bus.terc4_channel1, bus.terc4_channel2};
  endfunction
  task automatic expand(input pkt_t pk, input bit last_pkt);
    logic [31:0] hv;
    logic [63:0] sv [4];
    obs_t e;
    hv = {bch({32'h0, pk.h}, 24), pk.h};
    sv[0] = {bch(pk.s0, 56), pk.s0};
    sv[1] = {bch(pk.s1, 56), pk.s1};
    sv[2] = {bch(pk.s2, 56), pk.s2};
    sv[3] = {bch(pk.s3, 56), pk.s3};
    for (int k = 0; k < 32; k++) begin
      e.act = 1'b1;
      e.first = k == 0;
      e.last = last_pkt && k == 31;
      e.c0 = {k != 0, hv[k], 2'b00};
      for (int s = 0; s < 4; s++) begin
        e.c1[s] = sv[s][2*k];
        e.c2[s] = sv[s][2*k+1];
      end
      exp_q.push_back(e);
    end
  endtask
  task automatic push_pkt(input pkt_t pk);
    int w = 0;
    bus.packet_valid = 1'b1;
    {bus.header, bus.subpacket0, bus.subpacket1, bus.subpacket2, bus.subpacket3} = pk;
    while (!bus.packet_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    total_cnt++;
    if (!bus.packet_ready) $display("FAIL push_timeout packet_ready=0 required=1");
    else pass_cnt++;
    @(negedge clk);
    bus.packet_valid = 1'b0;
    pkt_q.push_back(pk);
  endtask
  task automatic start_island();
    int n = pkt_q.size() < MP ? pkt_q.size() : MP;
    total_cnt++;
    if (int'(bus.pending_packets) !== n) $display("FAIL pending_packets got=%0d exp=%0d", bus.pending_packets, n);
    else pass_cnt++;
    bus.island_start = 1'b1;
    for (int i = 0; i < n; i++) expand(pkt_q.pop_front(), i == n - 1);
  endtask
  task automatic stream(input int mid_at, input int chains, input int abort_at);
    obs_t e, o;
    logic [1:0] sy;
    int cyc = 0;
    int ch = chains;
    bit acc = 1'b0;
    sy = {bus.vsync, bus.hsync};
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e.c0[1:0] = sy;
      o = sample();
      total_cnt++;
      if (o !== e) $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, o, e);
      else pass_cnt++;
      bus.island_start = 1'b0;
      if (acc) bus.packet_valid = 1'b0;
      acc = bus.packet_valid && bus.packet_ready;
      sy = 2'($urandom);
      bus.vsync = sy[1];
      bus.hsync = sy[0];
      if (cyc == mid_at) bus.island_start = 1'b1;
      if (exp_q.size() == 0 && ch > 0) begin
        ch--;
        start_island();
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        exp_q.delete();
        pkt_q.delete();
      end
      cyc++;
      @(negedge clk);
    end
    bus.island_start = 1'b0;
    if (abort_at < 0) begin
      o = sample();
      total_cnt++;
      if (o !== {3'b000, 2'b00, sy, 8'h00}) $display("FAIL idle_after_island got=%h exp=%h", o, {3'b000, 2'b00, sy, 8'h00});
      else pass_cnt++;
    end
  endtask
  task automatic check_level(input string name, input int lvl);
    total_cnt++;
    if (int'(bus.fifo_level) !== lvl) $display("FAIL %s fifo_level got=%0d exp=%0d", name, bus.fifo_level, lvl);
    else pass_cnt++;
  endtask
  task automatic check_reset_state(input string name);
    total_cnt++;
    if (sample() !== '0) $display("FAIL %s outputs got=%h exp=0", name, sample());
    else pass_cnt++;
    total_cnt++;
    if ({bus.packet_ready, bus.pending_packets, bus.fifo_level} !== {1'b1, 2'd0, 3'd0})
      $display("FAIL %s status ready=%b pending=%0d level=%0d exp 1/0/0", name, bus.packet_ready, bus.pending_packets, bus.fifo_level);
    else pass_cnt++;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_zero_packet();
    push_pkt('0);
    start_island();
    stream(-1, 0, -1);
    check_level("zero_packet", 0);
  endtask
  task automatic test_empty_start();
    bus.island_start = 1'b1;
    @(negedge clk);
    bus.island_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.island_active, bus.packet_first_clock, bus.terc4_channel1} !== 6'd0)
        $display("FAIL empty_start active=%b first=%b ch1=%h exp 0", bus.island_active, bus.packet_first_clock, bus.terc4_channel1);
      else pass_cnt++;
    end
    check_level("empty_start", 0);
  endtask
  task automatic test_max_packets();
    repeat (3) push_pkt(rand_pkt());
    start_island();
    stream(-1, 0, -1);
    check_level("max_packets", 1);
    start_island();
    stream(-1, 0, -1);
    check_level("max_packets_tail", 0);
  endtask
  task automatic test_fifo_full();
    pkt_t p5 = rand_pkt();
    repeat (4) push_pkt(rand_pkt());
    bus.packet_valid = 1'b1;
    {bus.header, bus.subpacket0, bus.subpacket1, bus.subpacket2, bus.subpacket3} = p5;
    repeat (3) begin
      total_cnt++;
      if (bus.packet_ready !== 1'b0) $display("FAIL fifo_full packet_ready got=%b exp=0", bus.packet_ready);
      else pass_cnt++;
      check_level("fifo_full", 4);
      @(negedge clk);
    end
    start_island();
    pkt_q.push_back(p5);
    stream(-1, 0, -1);
    check_level("fifo_full_after", 3);
    start_island();
    stream(-1, 0, -1);
    start_island();
    stream(-1, 0, -1);
    check_level("fifo_full_drained", 0);
  endtask
  task automatic test_mid_start();
    repeat (3) push_pkt(rand_pkt());
    start_island();
    stream(5, 0, -1);
    check_level("mid_start", 1);
    start_island();
    stream(-1, 0, -1);
  endtask
  task automatic test_back_to_back();
    repeat (4) push_pkt(rand_pkt());
    start_island();
    stream(-1, 1, -1);
    check_level("back_to_back", 0);
  endtask
  task automatic test_reset_mid();
    repeat (3) push_pkt(rand_pkt());
    start_island();
    stream(-1, 0, 42);
    check_reset_state("reset_mid");
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      repeat (2) push_pkt(rand_pkt());
      start_island();
      stream(-1, 0, -1);
    end
    check_level("random", 0);
  endtask
  initial begin
    bus.packet_valid = 1'b0;
    bus.island_start = 1'b0;
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    {bus.header, bus.subpacket0, bus.subpacket1, bus.subpacket2, bus.subpacket3} = '0;
    test_reset();
    test_zero_packet();
    test_empty_start();
    test_max_packets();
    test_fifo_full();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
